// File: rtl/seq_div32_pkg.sv
// Shared definitions for the iterative divider: widths, state encoding, latency
// constants and the magnitude / conditional-negate helpers.
package seq_div32_pkg;

  localparam int unsigned WIDTH       = 32;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned DIV_LATENCY = WIDTH + 2;

  localparam logic [WIDTH-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

  // Result sign context latched when an operation is accepted
  typedef struct packed {
    logic neg_q;
    logic neg_r;
  } sign_ctx_t;

  // Two's-complement magnitude when signed; wraps modulo 2^WIDTH (|0x80000000| = 0x80000000)
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? WIDTH'(-x) : x;
  endfunction

endpackage

// File: rtl/seq_div32_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor magnitude, and keep the difference only when no borrow occurs.
module seq_div32_div_step
  import seq_div32_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor keeps shifted below 2*divisor, so trial[WIDTH] is exactly the borrow
  always_comb begin
    shifted  = {rem, q_msb};
    trial    = shifted - {1'b0, divisor};
    q_bit    = ~trial[WIDTH];
    next_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div32.sv
// Iterative 32-bit signed/unsigned divider: one restoring step per clock,
// start/busy/done handshake, divide-by-zero shortcut.
module seq_div32
  import seq_div32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_e       state;
  div_state_e       state_next;
  logic             accept_c;
  logic             zero_c;
  logic             last_step_c;

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvsr;
  sign_ctx_t        sgn;

  logic [WIDTH-1:0] step_rem;
  logic             step_bit;

  seq_div32_div_step u_step (
    .rem      (rem),
    .q_msb    (q_reg[WIDTH-1]),
    .divisor  (dvsr),
    .next_rem (step_rem),
    .q_bit    (step_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and accept decode
  always_comb begin
    state_next  = state;
    accept_c    = 1'b0;
    zero_c      = (divisor == '0);
    last_step_c = (count == CNT_W'(WIDTH - 1));
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept_c   = 1'b1;
          state_next = zero_c ? S_DONE : S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_step_c) begin
          state_next = S_FIX;
        end
      end
      S_FIX:   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and output registers; busy/done lag the state by one edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rem         <= '0;
      q_reg       <= '0;
      dvsr        <= '0;
      sgn         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state == S_RUN) || (state == S_FIX);
      done <= (state == S_DONE);

      if (accept_c) begin
        count       <= '0;
        rem         <= '0;
        q_reg       <= mag(dividend, is_signed);
        dvsr        <= mag(divisor, is_signed);
        sgn.neg_q   <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        sgn.neg_r   <= is_signed & dividend[WIDTH-1];
        div_by_zero <= zero_c;
        if (zero_c) begin
          quotient  <= DIV_ZERO_Q;
          remainder <= dividend;
        end
      end else if (state == S_RUN) begin
        rem   <= step_rem;
        q_reg <= {q_reg[WIDTH-2:0], step_bit};
        count <= count + CNT_W'(1);
      end else if (state == S_FIX) begin
        quotient  <= neg_if(q_reg, sgn.neg_q);
        remainder <= neg_if(rem, sgn.neg_r);
      end
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed vector table plus hand-written
// sequences for start-during-RUN, back-to-back start and mid-operation reset.
module tb_seq_div32;
  import seq_div32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  seq_div32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request for one edge, then scramble the operand inputs
  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
    start     = 1'b1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0;
  endtask

  // Edges from the accepting edge to the first done; counts cycles busy was low while waiting
  task automatic wait_done(output int lat, output int busy_low);
    lat      = 0;
    busy_low = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_low++;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    int busy_low;
    issue(v.sg, v.a, v.b);
    wait_done(lat, busy_low);
    chk({tag, " latency"}, 32'(lat), 32'(v.lat));
    chk({tag, " busy_low_while_running"}, 32'(busy_low), 32'd0);
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, " quotient"}, quotient, v.q);
    chk({tag, " remainder"}, remainder, v.r);
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.dz});
    @(posedge clk);
    #1;
    chk({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int busy_low;
    int early;
    int seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'h2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 34};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'h2,          32'h7FFF_FFFC,  32'h1,          1'b0, 34};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[4]  = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 34};
    vecs[5]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 1};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'h0,          1'b0, 34};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'h1,          32'hFFFF_FFFF,  32'h0,          1'b0, 34};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 34};
    vecs[9]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0, 34};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 34};
    vecs[11] = '{1'b0, 32'd3,          32'd5,          32'd0,          32'd3,          1'b0, 34};
    vecs[12] = '{1'b0, 32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0,          1'b0, 34};

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset quotient", quotient, 32'd0);
    chk("reset remainder", remainder, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // start during RUN is ignored; start held in DONE launches the next op
    issue(1'b0, 32'd100, 32'd7);
    early = 0;
    for (int n = 1; n <= 33; n++) begin
      @(posedge clk);
      #1;
      if (done) early++;
      if (n == 5) begin
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd10;
      end
      if (n == 6) start = 1'b0;
      if (n == 33) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
      end
    end
    chk("ignored_start early_done", 32'(early), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ignored_start done_at_34", {31'd0, done}, 32'd1);
    chk("ignored_start quotient", quotient, 32'd14);
    chk("ignored_start remainder", remainder, 32'd2);
    wait_done(lat, busy_low);
    chk("back2back latency", 32'(lat), 32'd34);
    chk("back2back quotient", quotient, 32'd3);
    chk("back2back remainder", remainder, 32'd0);
    @(posedge clk);
    #1;

    // Reset between edges in mid-RUN aborts with no done pulse
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset quotient", quotient, 32'd0);
    chk("midreset remainder", remainder, 32'd0);
    chk("midreset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("midreset no_activity", 32'(seen), 32'd0);
    run_vec(vecs[0], "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
